// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port byte-addressed memory between the
// instruction-fetch port (read-only) and the load/store port (read/write).
//
// A round-robin arbiter grants one request while IDLE. The winning request
// is latched and either issued to memory (ACCESS) or rejected at once as
// illegal. The response comes back to the owner as a one-cycle pulse (RESP).
//
// Ports:
//   clk, resetn_i          clock, asynchronous active-low reset
//   if_req_i / if_addr_i   fetch request (word reads only)
//   if_gnt_o               fetch request accepted this cycle (combinational)
//   if_rvalid_o/_rdata_o/_err_o  fetch response pulse, data, error
//   lsu_req_i/_addr_i/_we_i/_size_i/_wdata_i  load/store request
//   lsu_gnt_o              load/store request accepted this cycle (combinational)
//   lsu_rvalid_o/_rdata_o/_err_o load/store response pulse, data, error
//   mem_valid_o/_write_o/_write_size_o/_addr_o/_data_o  memory request
//   mem_valid_i/_data_i    memory completion and read data
module mem_arbiter #(
    parameter int BITSIZE        = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               resetn_i,
    input  logic               if_req_i,
    input  logic [31:0]        if_addr_i,
    output logic               if_gnt_o,
    output logic               if_rvalid_o,
    output logic [BITSIZE-1:0] if_rdata_o,
    output logic               if_err_o,
    input  logic               lsu_req_i,
    input  logic [31:0]        lsu_addr_i,
    input  logic               lsu_we_i,
    input  logic [1:0]         lsu_size_i,
    input  logic [BITSIZE-1:0] lsu_wdata_i,
    output logic               lsu_gnt_o,
    output logic               lsu_rvalid_o,
    output logic [BITSIZE-1:0] lsu_rdata_o,
    output logic               lsu_err_o,
    output logic [31:0]        mem_addr_o,
    output logic [BITSIZE-1:0] mem_data_o,
    input  logic [BITSIZE-1:0] mem_data_i,
    output logic               mem_write_o,
    output logic [1:0]         mem_write_size_o,
    output logic               mem_valid_o,
    input  logic               mem_valid_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    owner_t             owner_q, last_owner_q;
    logic [31:0]        addr_q;
    logic               we_q;
    logic [1:0]         size_q;
    logic [BITSIZE-1:0] wdata_q;
    logic               err_q;
    logic [BITSIZE-1:0] if_rdata_q, lsu_rdata_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               grant_if, grant_lsu, grant_any;
    logic               if_illegal, lsu_illegal, req_illegal;
    logic               timeout, access_done;
    logic [BITSIZE-1:0] resp_data;

    // Round-robin: the fetch port wins unless the LSU also asks and the
    // fetch port owned the previous access. Grants are masked during reset
    // so every output reads 0 while resetn_i is low.
    assign grant_if  = resetn_i && (state_q == S_IDLE) && if_req_i &&
                       (!lsu_req_i || (last_owner_q == OWN_LSU));
    assign grant_lsu = resetn_i && (state_q == S_IDLE) && lsu_req_i && !grant_if;
    assign grant_any = grant_if || grant_lsu;

    // Fetches are always word reads and must be word aligned.
    assign if_illegal = (if_addr_i[1:0] != 2'b00);

    // Sub-word writes are only legal at the word base because the memory
    // writes its byte lanes starting from the aligned word.
    // NOTE: every signal assigned in always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        lsu_illegal = 1'b1;
        case (lsu_size_i)
            2'b00:   lsu_illegal = lsu_we_i && (lsu_addr_i[1:0] != 2'b00);
            2'b01:   lsu_illegal = lsu_addr_i[0] || (lsu_we_i && lsu_addr_i[1]);
            2'b10:   lsu_illegal = (lsu_addr_i[1:0] != 2'b00);
            default: lsu_illegal = 1'b1;
        endcase
    end

    assign req_illegal = grant_if ? if_illegal : lsu_illegal;

    // A completing memory beat takes priority over a coinciding timeout.
    assign timeout     = (cnt_q == CNT_LAST);
    assign access_done = mem_valid_i || timeout;
    assign resp_data   = (mem_valid_i && !we_q) ? mem_data_i : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (grant_any) state_d = req_illegal ? S_RESP : S_ACCESS;
            S_ACCESS: if (access_done) state_d = S_RESP;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so
    // every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_LSU;
            addr_q       <= '0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            if_rdata_q   <= '0;
            lsu_rdata_q  <= '0;
            cnt_q        <= '0;
        end else if (grant_any) begin
            owner_q      <= grant_if ? OWN_IF : OWN_LSU;
            last_owner_q <= grant_if ? OWN_IF : OWN_LSU;
            addr_q       <= grant_if ? if_addr_i : lsu_addr_i;
            we_q         <= grant_lsu && lsu_we_i;
            size_q       <= grant_if ? 2'b10 : lsu_size_i;
            wdata_q      <= grant_if ? '0 : lsu_wdata_i;
            cnt_q        <= '0;
            err_q        <= req_illegal;
            // An illegal request skips ACCESS, so its zero read data is
            // loaded here rather than at memory completion.
            if (req_illegal) begin
                if (grant_if) begin
                    if_rdata_q <= '0;
                end else begin
                    lsu_rdata_q <= '0;
                end
            end
        end else if (state_q == S_ACCESS) begin
            cnt_q <= cnt_q + 1'b1;
            if (access_done) begin
                err_q <= !mem_valid_i;
                if (owner_q == OWN_IF) begin
                    if_rdata_q <= resp_data;
                end else begin
                    lsu_rdata_q <= resp_data;
                end
            end
        end
    end

    assign if_gnt_o     = grant_if;
    assign lsu_gnt_o    = grant_lsu;
    assign if_rvalid_o  = (state_q == S_RESP) && (owner_q == OWN_IF);
    assign lsu_rvalid_o = (state_q == S_RESP) && (owner_q == OWN_LSU);
    assign if_err_o     = if_rvalid_o && err_q;
    assign lsu_err_o    = lsu_rvalid_o && err_q;
    assign if_rdata_o   = if_rdata_q;
    assign lsu_rdata_o  = lsu_rdata_q;

    assign mem_valid_o      = (state_q == S_ACCESS);
    assign mem_write_o      = mem_valid_o && we_q;
    assign mem_write_size_o = size_q;
    assign mem_addr_o       = addr_q;
    assign mem_data_o       = wdata_q;

endmodule
